// File: rtl/controle_temporizador.sv
`default_nettype none
// ============================================================================
// Module   : controle_temporizador
// Purpose  : Single-clock timebase and duration controller. A programmable
//            prescaler produces a one-cycle 'tick' enable (period div+1).
//            One timed activation of 'duracao' ticks is sequenced through a
//            start/busy/done handshake, with abort. No derived clocks.
// Ports    : clock, reset     - system clock, synchronous active-high reset
//            cfg_we, cfg_div  - divide register write (honoured in IDLE only)
//            start, duracao   - request an activation of 'duracao' ticks
//            abort            - cancel the running activation
//            tick             - free-running one-cycle timebase pulse
//            busy             - activation in progress
//            done             - one-cycle pulse on normal completion
//            restante         - ticks remaining in the current activation
// Revision : 1.0 - initial release
// ============================================================================
module controle_temporizador #(
  parameter int DIV_WIDTH            = 22,
  parameter int unsigned DIV_DEFAULT = 4194303,
  parameter int TIME_WIDTH           = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  start,
  input  logic [TIME_WIDTH-1:0] duracao,
  input  logic                  abort,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic [TIME_WIDTH-1:0] restante
);

  localparam logic [DIV_WIDTH-1:0]  DIV_RESET = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0]  CNT_ONE   = DIV_WIDTH'(1);
  localparam logic [TIME_WIDTH-1:0] TIME_ONE  = TIME_WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 done_reg;

  logic cfg_accept;
  logic run_load;

  // Configuration and run-start are only honoured in IDLE; both restart the
  // prescaler so the new period (or the activation) begins phase-aligned.
  assign cfg_accept = (state == ST_IDLE) && cfg_we;
  assign run_load   = (state == ST_IDLE) && start && (duracao != '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Abort wins over a same-cycle completing tick.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (duracao != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (tick && (restante == TIME_ONE)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: divide register, prescaler, remaining-time counter, done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg  <= DIV_RESET;
      cnt      <= '0;
      tick     <= 1'b0;
      restante <= '0;
      done_reg <= 1'b0;
    end else begin
      if (cfg_accept) begin
        div_reg <= cfg_div;
      end

      // A forced clear suppresses the tick so a stale wrap cannot leak into
      // a freshly started period.
      if (cfg_accept || run_load) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt == div_reg) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_ONE;
        tick <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (run_load) begin
            restante <= duracao;
          end
        end
        ST_RUN: begin
          if (abort) begin
            restante <= '0;
          end else if (tick) begin
            if (restante <= TIME_ONE) begin
              restante <= '0;
            end else begin
              restante <= restante - TIME_ONE;
            end
          end
        end
        default: begin
          restante <= '0;
        end
      endcase

      done_reg <= (state_next == ST_DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == ST_RUN);
    done = done_reg;
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_temporizador.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_temporizador
// Purpose  : Randomized self-checking bench for controle_temporizador. A
//            reference model derives every output from the timing formulas
//            (tick phase, done cycle, remaining ticks) and pushes the expected
//            outputs of the next cycle into a queue; a monitor pops them and
//            compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_temporizador;

  localparam int          DIV_WIDTH   = 22;
  localparam int          TIME_WIDTH  = 8;
  localparam longint      DIV_DEFAULT = 4194303;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  cfg_we = 1'b0;
  logic [DIV_WIDTH-1:0]  cfg_div = '0;
  logic                  start = 1'b0;
  logic [TIME_WIDTH-1:0] duracao = '0;
  logic                  abort = 1'b0;
  logic                  tick;
  logic                  busy;
  logic                  done;
  logic [TIME_WIDTH-1:0] restante;

  controle_temporizador dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_div  (cfg_div),
    .start    (start),
    .duracao  (duracao),
    .abort    (abort),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .restante (restante)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    logic   tick;
    logic   busy;
    logic   done;
    int     restante;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 completing.
  int     m_mode  = 0;
  longint m_t0    = 0;   // first cycle in which the prescaler count is 0
  longint m_div   = DIV_DEFAULT;
  longint m_n     = 0;   // cycle in which the activation was accepted
  longint m_dur   = 0;

  // Inputs for the current cycle are already on the pins; predict the
  // outputs of the following cycle.
  task automatic model_step();
    longint e;
    exp_t   x;
    e = longint'(cyc) + 1;
    if (reset) begin
      m_mode = 0;
      m_t0   = e;
      m_div  = DIV_DEFAULT;
    end else begin
      case (m_mode)
        0: begin
          if (cfg_we) begin
            m_div = longint'(cfg_div);
            m_t0  = e;
          end
          if (start) begin
            if (duracao != 0) begin
              m_mode = 1;
              m_n    = cyc;
              m_dur  = longint'(duracao);
              m_t0   = e;
            end else begin
              m_mode = 2;
            end
          end
        end
        1: begin
          if (abort) m_mode = 0;
          else if (e == m_n + 2 + m_dur * (m_div + 1)) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    x.cyc  = int'(e);
    x.tick = (e > m_t0) && (((e - m_t0) % (m_div + 1)) == 0);
    x.busy = (m_mode == 1);
    x.done = (m_mode == 2);
    if (m_mode == 1) begin
      if (e == m_n + 1) x.restante = int'(m_dur);
      else x.restante = int'(m_dur - (e - m_n - 2) / (m_div + 1));
    end else begin
      x.restante = 0;
    end
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic we, input int dv,
                       input logic st, input int du, input logic ab);
    @(posedge clock);
    #1;
    reset   = r;
    cfg_we  = we;
    cfg_div = DIV_WIDTH'(dv);
    start   = st;
    duracao = TIME_WIDTH'(du);
    abort   = ab;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: compares DUT outputs of each cycle against the queued prediction.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_check cycle %0d: expectation not compared", x.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        x = exp_q.pop_front();
        checks++;
        if (tick !== x.tick || busy !== x.busy || done !== x.done ||
            restante !== TIME_WIDTH'(x.restante)) begin
          errors++;
          $display("FAIL outputs cycle %0d: got tick=%b busy=%b done=%b restante=%0d, expected tick=%b busy=%b done=%b restante=%0d",
                   cyc, tick, busy, done, restante, x.tick, x.busy, x.done, x.restante);
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 90000);
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    // Reset
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(20);   // default divide: no tick expected for a long time

    // Basic timing: divide 3, two-tick activation
    drive(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 0, 1'b1, 2, 1'b0);
    idle(14);

    // Zero-length activation
    drive(1'b0, 1'b0, 0, 1'b1, 0, 1'b0);
    idle(4);

    // Abort on the completing tick (divide 1, one tick)
    drive(1'b0, 1'b1, 1, 1'b0, 0, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 0, 1'b1, 1, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    idle(5);

    // Start and configuration ignored while running
    drive(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 3, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 0, 1'b1, 9, 1'b0);
    idle(16);

    // Degenerate divide
    drive(1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 3, 1'b0);
    idle(6);

    // Start together with configuration
    drive(1'b0, 1'b1, 2, 1'b1, 2, 1'b0);
    idle(12);

    // Reset mid-run, then default divide again
    drive(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 5, 1'b0);
    idle(4);
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(300);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 5)),
            ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 4)),
            ($urandom_range(0, 24) == 0));
    end
    idle(3);

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() > 1) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected at most 1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
